// File: rtl/gelu_out_pack_fifo.sv
// Packs the clipped GELU/requant element stream into PACK-lane words.
// Each row starts at lane 0, and a partial word at a row end is zero-padded.
// Packed words are buffered in a FIFO, tagged with row-end (tuser) and matrix-end (tlast).
module gelu_out_pack_fifo #(
  parameter int unsigned D_W          = 8,
  parameter int unsigned PACK         = 4,
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [D_W-1:0]          in_tdata,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    in_tlast,
  output logic [D_W*PACK-1:0]     out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tuser,
  output logic                    out_tlast,
  input  logic [MATRIXSIZE_W-1:0] DIM1,
  input  logic [MATRIXSIZE_W-1:0] DIM2,
  output logic                    err_tlast
);

  localparam int unsigned WORD_W = D_W * PACK;
  localparam int unsigned LANE_W = $clog2(PACK);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              last;
    logic              user;
    logic [WORD_W-1:0] data;
  } entry_t;

  logic [MATRIXSIZE_W-1:0]     dim1_q, dim2_q;
  logic [MATRIXSIZE_W-1:0]     col_cnt_q, row_cnt_q;
  logic [LANE_W-1:0]           lane_cnt_q;
  logic [PACK-1:0][D_W-1:0]    pack_q;
  entry_t                      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q;
  logic                        ready_en_q;

  logic                        first_c;
  logic [MATRIXSIZE_W-1:0]     dim1_c, dim2_c;
  logic                        full_c, accept_c, col_last_c, row_last_c, lane_last_c;
  logic                        push_c, pop_c;
  logic [PACK-1:0][D_W-1:0]    word_c;
  entry_t                      entry_c;

  // Effective dimensions, handshake and word-completion decode
  always_comb begin
    first_c     = (col_cnt_q == '0) && (row_cnt_q == '0);
    dim1_c      = first_c ? DIM1 : dim1_q;
    dim2_c      = first_c ? DIM2 : dim2_q;
    full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    // ready_en_q holds ready low through reset; dimension check matters only when idle
    in_tready   = ready_en_q && !full_c && (dim1_c != '0) && (dim2_c != '0);
    accept_c    = in_tvalid && in_tready;
    col_last_c  = (col_cnt_q == dim2_c - MATRIXSIZE_W'(1));
    row_last_c  = (row_cnt_q == dim1_c - MATRIXSIZE_W'(1));
    lane_last_c = (lane_cnt_q == LANE_W'(PACK - 1));
    push_c      = accept_c && (lane_last_c || col_last_c);
    pop_c       = (count_q != '0) && out_tready;
    for (int k = 0; k < int'(PACK); k++) begin
      if (LANE_W'(k) < lane_cnt_q)       word_c[k] = pack_q[k];
      else if (LANE_W'(k) == lane_cnt_q) word_c[k] = in_tdata;
      else                               word_c[k] = '0;
    end
    entry_c.data = word_c;
    entry_c.user = col_last_c;
    entry_c.last = col_last_c && row_last_c;
  end

  // Framing counters, dimension latch, pack register and tlast check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      dim1_q     <= '0;
      dim2_q     <= '0;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      lane_cnt_q <= '0;
      pack_q     <= '0;
      err_tlast  <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept_c) begin
        if (first_c) begin
          dim1_q <= DIM1;
          dim2_q <= DIM2;
        end
        if (col_last_c) begin
          col_cnt_q <= '0;
          row_cnt_q <= row_last_c ? '0 : row_cnt_q + MATRIXSIZE_W'(1);
        end else begin
          col_cnt_q <= col_cnt_q + MATRIXSIZE_W'(1);
        end
        if (push_c) begin
          lane_cnt_q <= '0;
          pack_q     <= '0;
        end else begin
          lane_cnt_q         <= lane_cnt_q + LANE_W'(1);
          pack_q[lane_cnt_q] <= in_tdata;
        end
        if (in_tlast != (row_last_c && col_last_c)) err_tlast <= 1'b1;
      end
    end
  end

  // Packed-word FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= entry_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_tvalid = (count_q != '0);
  assign out_tdata  = mem_q[rd_ptr_q].data;
  assign out_tuser  = mem_q[rd_ptr_q].user;
  assign out_tlast  = mem_q[rd_ptr_q].last;

endmodule

// File: tb/tb_gelu_out_pack_fifo.sv
// Directed bench for gelu_out_pack_fifo: packing, padding, backpressure, tlast error, reset, random flow.
module tb_gelu_out_pack_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic        in_tlast;
  logic [31:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tuser;
  logic        out_tlast;
  logic [15:0] DIM1;
  logic [15:0] DIM2;
  logic        err_tlast;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rand_rdy = 1'b0;
  logic        rand_vld = 1'b0;
  logic [33:0] got[$];

  gelu_out_pack_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tuser  (out_tuser),
    .out_tlast  (out_tlast),
    .DIM1       (DIM1),
    .DIM2       (DIM2),
    .err_tlast  (err_tlast)
  );

  always #5 clk = ~clk;

  // Record every output handshake as {tlast, tuser, data}
  always @(negedge clk) begin
    if (rst_n && out_tvalid && out_tready) got.push_back({out_tlast, out_tuser, out_tdata});
  end

  // Random output backpressure when enabled
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat; called at posedge+1, returns at posedge+1 after acceptance
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    if (rand_vld) begin
      while ($urandom_range(0, 99) >= 70) begin
        @(posedge clk); #1;
      end
    end
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    @(negedge clk);
    while (!in_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(in_tready), 64'(1));
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_words(input int n, input string tag);
    int c = 0;
    while (got.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 64'(got.size()), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic chk_word(input string tag, input int idx, input logic l, input logic u,
                          input logic [31:0] d);
    logic [33:0] w;
    w = (idx < got.size()) ? got[idx] : 34'h3_ffff_ffff;
    chk(tag, 64'(w), 64'({l, u, d}));
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [7:0]  v [15];
    rst_n      = 1'b0;
    in_tdata   = '0;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    out_tready = 1'b1;
    DIM1       = 16'd2;
    DIM2       = 16'd8;

    // Reset state
    #2;
    chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_in_tready",  64'(in_tready),  64'(0));
    chk("rst_out_tdata",  64'(out_tdata),  64'(0));
    chk("rst_out_tuser",  64'(out_tuser),  64'(0));
    chk("rst_out_tlast",  64'(out_tlast),  64'(0));
    chk("rst_err_tlast",  64'(err_tlast),  64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready_dims_ok", 64'(in_tready), 64'(1));
    DIM1 = 16'd0;
    #1 chk("idle_ready_dim1_zero", 64'(in_tready), 64'(0));
    DIM1 = 16'd2;
    DIM2 = 16'd0;
    #1 chk("idle_ready_dim2_zero", 64'(in_tready), 64'(0));
    DIM2 = 16'd8;
    @(posedge clk); #1;

    // 2x8 matrix, elements 1..16
    got.delete();
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), i == 16);
      if (i == 4) begin
        chk("latency_valid", 64'(out_tvalid), 64'(1));
        chk("latency_data",  64'(out_tdata),  64'(32'h04030201));
      end
    end
    wait_words(4, "m1_count");
    chk_word("m1_w0", 0, 1'b0, 1'b0, 32'h04030201);
    chk_word("m1_w1", 1, 1'b0, 1'b1, 32'h08070605);
    chk_word("m1_w2", 2, 1'b0, 1'b0, 32'h0C0B0A09);
    chk_word("m1_w3", 3, 1'b1, 1'b1, 32'h100F0E0D);
    chk("m1_err_clear", 64'(err_tlast), 64'(0));

    // 1x6 matrix, zero-padded tail word
    got.delete();
    DIM1 = 16'd1;
    DIM2 = 16'd6;
    for (int i = 1; i <= 6; i++) send(8'(8'hF0 + i), i == 6);
    wait_words(2, "pad_count");
    chk_word("pad_w0", 0, 1'b0, 1'b0, 32'hF4F3F2F1);
    chk_word("pad_w1", 1, 1'b1, 1'b1, 32'h0000F6F5);

    // Backpressure: 2x64 matrix with output stalled until the FIFO fills
    got.delete();
    DIM1 = 16'd2;
    DIM2 = 16'd64;
    out_tready = 1'b0;
    for (int i = 1; i <= 64; i++) send(8'(i), 1'b0);
    chk("full_ready_low", 64'(in_tready),  64'(0));
    chk("full_valid",     64'(out_tvalid), 64'(1));
    in_tdata   = 8'd65;
    in_tvalid  = 1'b1;
    out_tready = 1'b1;
    @(negedge clk);
    chk("full_no_passthru", 64'(in_tready), 64'(0));
    @(posedge clk); #1;
    chk("ready_after_pop", 64'(in_tready), 64'(1));
    for (int i = 65; i <= 128; i++) send(8'(i), i == 128);
    wait_words(32, "bp_count");
    for (int w = 0; w < 32; w++) begin
      exp_w = {8'(4*w + 4), 8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1)};
      chk_word($sformatf("bp_w%0d", w), w, w == 31, (w % 16) == 15, exp_w);
    end

    // Misplaced in_tlast on element 3: sticky error, identical data
    got.delete();
    DIM1 = 16'd2;
    DIM2 = 16'd8;
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), i == 3);
      if (i == 3) chk("err_set", 64'(err_tlast), 64'(1));
    end
    wait_words(4, "err_count");
    chk_word("err_w0", 0, 1'b0, 1'b0, 32'h04030201);
    chk_word("err_w1", 1, 1'b0, 1'b1, 32'h08070605);
    chk_word("err_w2", 2, 1'b0, 1'b0, 32'h0C0B0A09);
    chk_word("err_w3", 3, 1'b1, 1'b1, 32'h100F0E0D);
    chk("err_sticky", 64'(err_tlast), 64'(1));

    // Reset mid-row with a word buffered
    out_tready = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(8'h50 + i), 1'b0);
    chk("prereset_valid", 64'(out_tvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("midrst_in_tready",  64'(in_tready),  64'(0));
    chk("midrst_err_tlast",  64'(err_tlast),  64'(0));
    repeat (2) @(posedge clk);
    #1;
    got.delete();
    DIM1       = 16'd1;
    DIM2       = 16'd4;
    out_tready = 1'b1;
    rst_n      = 1'b1;
    send(8'd9, 1'b0);
    send(8'd8, 1'b0);
    send(8'd7, 1'b0);
    send(8'd6, 1'b1);
    wait_words(1, "postrst_first");
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_count", 64'(got.size()), 64'(1));
    chk_word("postrst_w0", 0, 1'b1, 1'b1, 32'h06070809);

    // Random valid/ready, 3x5 matrix
    got.delete();
    DIM1 = 16'd3;
    DIM2 = 16'd5;
    for (int e = 0; e < 15; e++) v[e] = 8'(8'h83 + 8'(e * 29));
    rand_rdy = 1'b1;
    rand_vld = 1'b1;
    for (int e = 0; e < 15; e++) send(v[e], e == 14);
    wait_words(6, "rnd_count");
    rand_rdy = 1'b0;
    rand_vld = 1'b0;
    @(posedge clk); #2;
    out_tready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      chk_word($sformatf("rnd_r%0d_w0", r), 2*r, 1'b0, 1'b0,
               {v[5*r+3], v[5*r+2], v[5*r+1], v[5*r]});
      chk_word($sformatf("rnd_r%0d_w1", r), 2*r + 1, r == 2, 1'b1, {24'h0, v[5*r+4]});
    end
    chk("rnd_err_clear", 64'(err_tlast), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
